multiplicador_sat_param: RTL and testbench

Parametrised sequential shift-and-add multiplier with selectable signed/unsigned mode and optional saturation. It is the generalised successor to the 8-bit repeated-addition multiplier in the ULA datapath. It fixes latency at N+1 cycles regardless of operand values, latches operands at START, and exposes both the full 2N-bit product and an N-bit clamped result. The ULA control FSM drives it through a START/Pronto handshake.

---
 rtl/mult_pkg.sv | 27 ++
 rtl/saturador_param.sv | 39 +++
 rtl/multiplicador_sat_param.sv | 111 +++++++++++
 tb/tb_multiplicador_sat_param.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the parametrised shift-and-add multiplier.
package mult_pkg;

    typedef enum logic [1:0] {
        OCIOSO,
        CALCULANDO,
        FINALIZANDO
    } estado_t;

    // Bit patterns in the low n bits of a 32-bit word (n <= 16).
    function automatic logic [31:0] max_sinal(input int n);
        return (32'd1 << (n - 1)) - 32'd1;
    endfunction

    function automatic logic [31:0] min_sinal(input int n);
        return 32'd1 << (n - 1);
    endfunction

    function automatic logic [31:0] max_sem_sinal(input int n);
        return (32'd1 << n) - 32'd1;
    endfunction

    function automatic int cnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/saturador_param.sv
// Combinational range check and clamp of a 2N-bit product down to N bits.
module saturador_param
    import mult_pkg::*;
#(
    parameter int N       = 8,
    parameter bit SATURAR = 1'b1
) (
    input  logic [2*N-1:0] produto,
    input  logic           sinal,
    output logic [N-1:0]   resultado,
    output logic           overflow
);

    localparam logic [31:0] MAX_S_W = max_sinal(N);
    localparam logic [31:0] MIN_S_W = min_sinal(N);
    localparam logic [31:0] MAX_U_W = max_sem_sinal(N);
    localparam logic [N-1:0] MAX_S = MAX_S_W[N-1:0];
    localparam logic [N-1:0] MIN_S = MIN_S_W[N-1:0];
    localparam logic [N-1:0] MAX_U = MAX_U_W[N-1:0];

    logic ovf_u;
    logic ovf_s;

    // Signed fits iff the top N+1 bits are a pure sign extension.
    assign ovf_u = |produto[2*N-1:N];
    assign ovf_s = !((&produto[2*N-1:N-1]) || !(|produto[2*N-1:N-1]));

    always_comb begin
        overflow  = sinal ? ovf_s : ovf_u;
        resultado = produto[N-1:0];
        if (SATURAR && overflow) begin
            if (!sinal)
                resultado = MAX_U;
            else
                resultado = produto[2*N-1] ? MIN_S : MAX_S;
        end
    end

endmodule

// File: rtl/multiplicador_sat_param.sv
// Sequential shift-and-add multiplier, signed/unsigned, fixed N+1 cycle latency,
// with full product and saturated/wrapped N-bit result.
module multiplicador_sat_param
    import mult_pkg::*;
#(
    parameter int N       = 8,
    parameter bit SATURAR = 1'b1
) (
    input  logic           CLOCK,
    input  logic           RESET,
    input  logic           START,
    input  logic           SINAL,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    output logic [N-1:0]   Resultado,
    output logic [2*N-1:0] Produto,
    output logic           Overflow,
    output logic           Pronto,
    output logic           Ocupado
);

    localparam int CW = cnt_w(N);
    localparam logic [CW-1:0] ULTIMO = CW'(N - 1);

    estado_t        estado, proximo;
    logic [N-1:0]   mcand, mplier;
    logic [2*N-1:0] acc;
    logic [CW-1:0]  cnt;
    logic           sinal_neg, sinal_r;

    logic [N-1:0]   mag_a, mag_b;
    logic [N:0]     soma;
    logic [2*N-1:0] prod_final;
    logic [N-1:0]   res_sat;
    logic           ovf_sat;

    // -2^(N-1) negates to itself, which is the correct unsigned magnitude.
    assign mag_a      = (SINAL && A[N-1]) ? -A : A;
    assign mag_b      = (SINAL && B[N-1]) ? -B : B;
    assign soma       = {1'b0, acc[2*N-1:N]} + {1'b0, mcand};
    assign prod_final = sinal_neg ? -acc : acc;

    saturador_param #(
        .N      (N),
        .SATURAR(SATURAR)
    ) u_sat (
        .produto  (prod_final),
        .sinal    (sinal_r),
        .resultado(res_sat),
        .overflow (ovf_sat)
    );

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) estado <= OCIOSO;
        else       estado <= proximo;
    end

    always_comb begin
        proximo = estado;
        unique case (estado)
            OCIOSO:      if (START) proximo = CALCULANDO;
            CALCULANDO:  if (cnt == ULTIMO) proximo = FINALIZANDO;
            FINALIZANDO: proximo = OCIOSO;
            default:     proximo = OCIOSO;
        endcase
    end

    always_ff @(posedge CLOCK or posedge RESET) begin
        if (RESET) begin
            mcand     <= '0;
            mplier    <= '0;
            acc       <= '0;
            cnt       <= '0;
            sinal_neg <= 1'b0;
            sinal_r   <= 1'b0;
            Resultado <= '0;
            Produto   <= '0;
            Overflow  <= 1'b0;
            Pronto    <= 1'b0;
            Ocupado   <= 1'b0;
        end else begin
            Pronto <= 1'b0;
            unique case (estado)
                OCIOSO: if (START) begin
                    mcand     <= mag_a;
                    mplier    <= mag_b;
                    sinal_neg <= SINAL & (A[N-1] ^ B[N-1]);
                    sinal_r   <= SINAL;
                    acc       <= '0;
                    cnt       <= '0;
                    Ocupado   <= 1'b1;
                end
                CALCULANDO: begin
                    // Carry out of the N+1-bit add lands in the new MSB.
                    acc    <= mplier[0] ? {soma, acc[N-1:1]} : {1'b0, acc[2*N-1:1]};
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                end
                FINALIZANDO: begin
                    Produto   <= prod_final;
                    Resultado <= res_sat;
                    Overflow  <= ovf_sat;
                    Pronto    <= 1'b1;
                    Ocupado   <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_multiplicador_sat_param.sv
// Directed and random checks of the N=8 multiplier, saturating and wrapping builds.
module tb_multiplicador_sat_param;

    logic       CLOCK = 1'b0;
    logic       RESET = 1'b1;
    logic       START = 1'b0;
    logic       SINAL = 1'b0;
    logic [7:0] A = '0;
    logic [7:0] B = '0;

    logic [7:0]  res_s, res_w;
    logic [15:0] prod_s, prod_w;
    logic        ovf_s, ovf_w, pronto_s, pronto_w, ocup_s, ocup_w;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 CLOCK = ~CLOCK;

    multiplicador_sat_param #(.N(8), .SATURAR(1'b1)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .START(START), .SINAL(SINAL), .A(A), .B(B),
        .Resultado(res_s), .Produto(prod_s), .Overflow(ovf_s), .Pronto(pronto_s), .Ocupado(ocup_s)
    );

    multiplicador_sat_param #(.N(8), .SATURAR(1'b0)) dut_w (
        .CLOCK(CLOCK), .RESET(RESET), .START(START), .SINAL(SINAL), .A(A), .B(B),
        .Resultado(res_w), .Produto(prod_w), .Overflow(ovf_w), .Pronto(pronto_w), .Ocupado(ocup_w)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: integer product, then range rules applied to the plain value.
    task automatic model(input bit sg, input logic [7:0] a, input logic [7:0] b,
                         output logic [15:0] prod, output logic [7:0] rs,
                         output logic [7:0] rw, output logic ovf);
        int pa, pb, p;
        logic [31:0] pv;
        pa   = sg ? int'($signed(a)) : int'(a);
        pb   = sg ? int'($signed(b)) : int'(b);
        p    = pa * pb;
        pv   = p;
        prod = pv[15:0];
        rw   = pv[7:0];
        ovf  = sg ? (p > 127 || p < -128) : (p > 255);
        if (!ovf)    rs = pv[7:0];
        else if (!sg) rs = 8'hFF;
        else         rs = (p < 0) ? 8'h80 : 8'h7F;
    endtask

    task automatic wait_pronto(input bit perturb, output int lat, output bit ocup_ok);
        lat     = 0;
        ocup_ok = 1'b1;
        while (pronto_s !== 1'b1 && lat < 40) begin
            if (ocup_s !== 1'b1 || ocup_w !== 1'b1) ocup_ok = 1'b0;
            @(negedge CLOCK);
            lat++;
            if (perturb && lat == 1) begin
                START = 1'b1; A = 8'd99; B = 8'd77; SINAL = ~SINAL;
            end
            if (perturb && lat == 2) START = 1'b0;
        end
    endtask

    // Called on a negedge; returns on the negedge where Pronto is seen.
    task automatic run(input string tag, input bit sg, input logic [7:0] a,
                       input logic [7:0] b, input bit perturb);
        logic [15:0] ep;
        logic [7:0]  ers, erw;
        logic        eo;
        int          lat;
        bit          ok;
        model(sg, a, b, ep, ers, erw, eo);
        START = 1'b1; SINAL = sg; A = a; B = b;
        @(negedge CLOCK);
        START = 1'b0;
        if (!perturb) begin
            A = 8'($urandom); B = 8'($urandom); SINAL = 1'($urandom);
        end
        wait_pronto(perturb, lat, ok);
        chk({tag, " latency"}, lat, 9);
        chk({tag, " ocupado_busy"}, ok, 1);
        chk({tag, " ocupado_done"}, {ocup_s, ocup_w}, 2'b00);
        chk({tag, " pronto_w"}, pronto_w, 1);
        chk({tag, " produto"}, prod_s, ep);
        chk({tag, " produto_w"}, prod_w, ep);
        chk({tag, " resultado_sat"}, res_s, ers);
        chk({tag, " resultado_wrap"}, res_w, erw);
        chk({tag, " overflow"}, ovf_s, eo);
        chk({tag, " overflow_w"}, ovf_w, eo);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int extra;

        RESET = 1'b1;
        @(negedge CLOCK);
        @(negedge CLOCK);
        chk("reset resultado", {res_s, res_w}, 16'h0);
        chk("reset produto", {prod_s, prod_w}, 32'h0);
        chk("reset overflow", {ovf_s, ovf_w}, 2'b00);
        chk("reset pronto", {pronto_s, pronto_w}, 2'b00);
        chk("reset ocupado", {ocup_s, ocup_w}, 2'b00);
        RESET = 1'b0;
        @(negedge CLOCK);

        // Consecutive runs start in the previous Pronto cycle (back-to-back).
        run("u12x10", 1'b0, 8'd12, 8'd10, 1'b0);
        run("u20x15", 1'b0, 8'd20, 8'd15, 1'b0);
        run("s-8x5", 1'b1, 8'hF8, 8'd5, 1'b0);
        run("s80x80", 1'b1, 8'h80, 8'h80, 1'b0);
        run("s-20x10", 1'b1, 8'hEC, 8'd10, 1'b0);
        run("s80xff", 1'b1, 8'h80, 8'hFF, 1'b0);
        run("s7fx7f", 1'b1, 8'h7F, 8'h7F, 1'b0);
        run("uffxff", 1'b0, 8'hFF, 8'hFF, 1'b0);
        run("zero", 1'b0, 8'd0, 8'd255, 1'b0);
        run("b2b", 1'b1, 8'h81, 8'h02, 1'b0);

        // Second START and operand changes mid-flight must be ignored, not queued.
        run("busy", 1'b0, 8'd12, 8'd10, 1'b1);
        extra = 0;
        repeat (14) begin
            @(negedge CLOCK);
            if (pronto_s === 1'b1) extra++;
        end
        chk("busy no_second_pronto", extra, 0);

        run("pre_rst", 1'b1, 8'hEC, 8'd10, 1'b0);
        START = 1'b1; SINAL = 1'b0; A = 8'd50; B = 8'd60;
        @(negedge CLOCK);
        START = 1'b0;
        repeat (3) @(negedge CLOCK);
        RESET = 1'b1;
        START = 1'b1;
        #1;
        chk("rst_async produto", prod_s, 16'h0);
        chk("rst_async resultado", res_s, 8'h0);
        chk("rst_async overflow", ovf_s, 1'b0);
        chk("rst_async ocupado", ocup_s, 1'b0);
        @(negedge CLOCK);
        RESET = 1'b0;
        START = 1'b0;
        chk("rst_wins_start ocupado", ocup_s, 1'b0);
        extra = 0;
        repeat (15) begin
            @(negedge CLOCK);
            if (pronto_s === 1'b1 || ocup_s === 1'b1) extra++;
        end
        chk("rst no_pronto", extra, 0);
        run("rst_after_3x7", 1'b0, 8'd3, 8'd7, 1'b0);

        for (int i = 0; i < 40; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge CLOCK);
            run($sformatf("rand%0d", i), 1'($urandom), 8'($urandom), 8'($urandom), 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
